// File: rtl/dac_mon_pkg.sv
// dac_mon_pkg: shared types, counter width and sample-format helper for the dac_mon slice.
package dac_mon_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, FILL, DONE} cap_state_t;

   localparam int unsigned ERR_CNT_W = 16;

   // Inverts the dw-1 magnitude bits of a sample held in the low bits of a word; sign bit kept.
   function automatic logic [31:0] fmt_conv(input logic [31:0] d, input int unsigned dw, input bit inv);
      logic [31:0] mask;
      mask = (32'd1 << (dw - 1)) - 32'd1;
      return inv ? (d ^ mask) : d;
   endfunction

endpackage

// File: rtl/dac_mon_chan.sv
// dac_mon_chan: one DAC channel -- sample register, step magnitude against the previous sample,
// registered slew compare, saturating error counter and max-step tracker.
module dac_mon_chan
   import dac_mon_pkg::*;
#(
   parameter int unsigned DW      = 14,
   parameter bit          FMT_INV = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_i,
   input  logic [DW-1:0]        dat_i,
   input  logic                 inv_i,
   input  logic                 clr_i,
   input  logic [DW-1:0]        thr_i,
   output logic [DW-1:0]        smp_o,
   output logic                 vld_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] cnt_o,
   output logic [DW-1:0]        max_o
);

   logic [DW-1:0]        smp_q, smp_d, prv_q, max_q, step_d;
   logic                 vld_q, have_q, chk_q, err_q, err_d;
   logic [ERR_CNT_W-1:0] cnt_q;
   logic [DW:0]          cur_x, prv_x, diff_d, mag_d;

   assign smp_d = DW'(fmt_conv(32'(dat_i), DW, FMT_INV));

   // Two's-complement view when the converted format is signed, plain magnitude otherwise.
   assign cur_x  = FMT_INV ? {smp_q[DW-1], smp_q} : {1'b0, smp_q};
   assign prv_x  = FMT_INV ? {prv_q[DW-1], prv_q} : {1'b0, prv_q};
   assign diff_d = cur_x - prv_x;
   assign mag_d  = diff_d[DW] ? -diff_d : diff_d;
   assign step_d = mag_d[DW] ? '1 : mag_d[DW-1:0];
   assign err_d  = chk_q && (step_d > thr_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         smp_q  <= '0;
         prv_q  <= '0;
         vld_q  <= 1'b0;
         have_q <= 1'b0;
         chk_q  <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
         max_q  <= '0;
      end else begin
         vld_q <= wr_i;
         chk_q <= wr_i && have_q && !inv_i;
         if (wr_i) begin
            smp_q  <= smp_d;
            prv_q  <= smp_q;
            have_q <= 1'b1;
         end else if (inv_i) begin
            have_q <= 1'b0;
         end
         if (clr_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
            max_q <= '0;
         end else begin
            err_q <= err_d;
            if (err_d && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
            if (chk_q && (step_d > max_q)) max_q <= step_d;
         end
      end
   end

   assign smp_o = smp_q;
   assign vld_o = vld_q;
   assign err_o = err_q;
   assign cnt_o = cnt_q;
   assign max_o = max_q;

endmodule

// File: rtl/dac_mon.sv
// dac_mon: multi-channel DAC bus monitor with parallel/interleaved strobe demux and slew checking.
// Optional capture FSM + buffer is compiled in when DAC_MON_CAPTURE_EN is defined.
module dac_mon
   import dac_mon_pkg::*;
#(
   parameter int unsigned CHN     = 2,
   parameter int unsigned DW      = 14,
   parameter int unsigned DEPTH   = 1024,
   parameter bit          FMT_INV = 1'b1
) (
   input  logic                       dac_clk_i,
   input  logic                       dac_rstn_i,
   input  logic                       mode_i,
   input  logic [CHN*DW-1:0]          dac_dat_i,
   input  logic [CHN-1:0]             dac_wrt_i,
   input  logic [$clog2(CHN)-1:0]     dac_sel_i,
   input  logic [DW-1:0]              slew_thr_i,
   input  logic                       clr_i,
   output logic [CHN*DW-1:0]          dac_o,
   output logic [CHN-1:0]             dac_vld_o,
   output logic [CHN-1:0]             slew_err_o,
   output logic [CHN*ERR_CNT_W-1:0]   err_cnt_o,
   output logic [CHN*DW-1:0]          max_step_o,
   input  logic                       arm_i,
   input  logic                       trig_imm_i,
   input  logic [$clog2(CHN)-1:0]     cap_ch_i,
   output logic                       cap_done_o,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
   output logic [DW-1:0]              rd_dat_o
);

   localparam int unsigned SW = $clog2(CHN);

   logic mode_q, inv_d;

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) mode_q <= 1'b0;
      else             mode_q <= mode_i;
   end

   // A mode switch drops every channel's history, same as a clear.
   assign inv_d = clr_i || (mode_i != mode_q);

   for (genvar c = 0; c < CHN; c++) begin : g_ch
      logic          wr_d;
      logic [DW-1:0] dat_d;

      assign wr_d  = mode_i ? (dac_wrt_i[0] && (dac_sel_i == SW'(c))) : dac_wrt_i[c];
      assign dat_d = mode_i ? dac_dat_i[0 +: DW] : dac_dat_i[c*DW +: DW];

      dac_mon_chan #(.DW(DW), .FMT_INV(FMT_INV)) u_chan (
         .clk_i  (dac_clk_i),
         .rst_ni (dac_rstn_i),
         .wr_i   (wr_d),
         .dat_i  (dat_d),
         .inv_i  (inv_d),
         .clr_i  (clr_i),
         .thr_i  (slew_thr_i),
         .smp_o  (dac_o[c*DW +: DW]),
         .vld_o  (dac_vld_o[c]),
         .err_o  (slew_err_o[c]),
         .cnt_o  (err_cnt_o[c*ERR_CNT_W +: ERR_CNT_W]),
         .max_o  (max_step_o[c*DW +: DW])
      );
   end

`ifdef DAC_MON_CAPTURE_EN
   localparam int unsigned AW = $clog2(DEPTH);

   cap_state_t    st_q, st_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] ch_q, ch_d;
   logic          pv_q, ch_vld_d, we_d;
   logic [DW-1:0] pd_q, ch_dat_d, rd_q;
   logic [DW-1:0] mem_q [DEPTH];

   // Selected with ch_d so the one-cycle delay line already follows a freshly armed channel.
   always_comb begin
      ch_vld_d = 1'b0;
      ch_dat_d = '0;
      for (int unsigned c = 0; c < CHN; c++) begin
         if (ch_d == SW'(c)) begin
            ch_vld_d = dac_vld_o[c];
            ch_dat_d = dac_o[c*DW +: DW];
         end
      end
   end

   // Samples are written one cycle late so the sample that raised slew_err_o lands in entry 0.
   always_comb begin
      st_d  = st_q;
      ptr_d = ptr_q;
      ch_d  = ch_q;
      we_d  = 1'b0;
      if (clr_i) begin
         st_d = IDLE;
      end else begin
         unique case (st_q)
            IDLE, DONE: if (arm_i) begin
               st_d  = ARMED;
               ch_d  = cap_ch_i;
               ptr_d = '0;
            end
            ARMED: if (trig_imm_i || (|slew_err_o)) begin
               st_d = FILL;
               we_d = pv_q;
            end
            FILL:    we_d = pv_q;
            default: st_d = IDLE;
         endcase
         if (we_d) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == AW'(DEPTH - 1)) st_d = DONE;
         end
      end
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         st_q  <= IDLE;
         ptr_q <= '0;
         ch_q  <= '0;
         pv_q  <= 1'b0;
         pd_q  <= '0;
         rd_q  <= '0;
      end else begin
         st_q  <= st_d;
         ptr_q <= ptr_d;
         ch_q  <= ch_d;
         pv_q  <= ch_vld_d;
         pd_q  <= ch_dat_d;
         rd_q  <= mem_q[rd_addr_i];
      end
   end

   always_ff @(posedge dac_clk_i) begin
      if (we_d) mem_q[ptr_q] <= pd_q;
   end

   assign cap_done_o = (st_q == DONE);
   assign rd_dat_o   = rd_q;
`else
   logic unused_cap;
   assign unused_cap = ^{arm_i, trig_imm_i, cap_ch_i, rd_addr_i};
   assign cap_done_o = 1'b0;
   assign rd_dat_o   = '0;
`endif

endmodule
